// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit LSB-first UART transmitter with a one-entry holding register
// Parity (none/odd/even) and stop-bit count (1/2) are set by parameters; frames advance on baud_tick.
module uart_tx #(
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       stopcnt_q, stopcnt_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       accept;
  logic       drain;
  logic       parity_bit;
  logic       more_stops;

  assign tx_ready   = !hold_full_q;
  assign accept     = tx_valid && !hold_full_q;
  assign parity_bit = (PARITY == 1) ? ~^shreg_q : ^shreg_q;
  assign more_stops = (STOP_BITS == 2) && !stopcnt_q;

  assign tx   = tx_q;
  assign busy = busy_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    tx_d      = tx_q;
    drain     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) begin
          shreg_d = hold_q;
          drain   = 1'b1;
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_tick) begin
          tx_d     = shreg_q[0];
          bitcnt_d = 3'd0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bitcnt_q != 3'd7) begin
            tx_d     = shreg_q[bitcnt_q + 3'd1];
            bitcnt_d = bitcnt_q + 3'd1;
          end else if (PARITY != 0) begin
            tx_d    = parity_bit;
            state_d = S_PARITY;
          end else begin
            tx_d      = 1'b1;
            stopcnt_d = 1'b0;
            state_d   = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          tx_d      = 1'b1;
          stopcnt_d = 1'b0;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (more_stops) begin
            stopcnt_d = 1'b1;
          end else if (hold_full_q) begin
            // Chain straight into the next start bit so back-to-back frames have no idle gap.
            shreg_d = hold_q;
            drain   = 1'b1;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    busy_d      = (state_d != S_IDLE);
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else if (drain) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      shreg_q     <= 8'd0;
      bitcnt_q    <= 3'd0;
      stopcnt_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      stopcnt_q   <= stopcnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter: the stage directly downstream of the baud-rate tick generator. It consumes the one-clock baud tick (one pulse per bit period) and serialises bytes from a valid/ready source onto the `tx` line in 8-data-bit, LSB-first frames. Parity and stop-bit count are set by parameters. A one-entry holding register lets the next byte be accepted mid-frame, so consecutive frames go out with no idle gap.

## Interface
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even; any other value is illegal.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `baud_tick`  in  1  one-`clk` pulse per bit period; synchronous to `clk`.
- `tx_data`  in  8  byte to send; sampled when `tx_valid && tx_ready`.
- `tx_valid`  in  1  source has a byte on `tx_data`.
- `tx_ready`  out  1  holding register empty; byte accepted this cycle if `tx_valid`.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- **Storage:** `hold` (8b) plus `hold_full` flag; `shreg` (8b) frame data; `bitcnt` (3b); `stopcnt` (1b).
- **Handshake:** `tx_ready = !hold_full` (combinational from the flag).
  - Accept sets `hold_full` and latches `hold <= tx_data`.
  - A drain (load into `shreg`) clears `hold_full`.
  - Accept and drain cannot coincide: accept needs the flag clear, drain needs it set.
- **States:** IDLE, SYNC, START, DATA, PARITY, STOP.
- **IDLE:** `tx = 1`. If `hold_full`: load `shreg <= hold`, clear `hold_full`, go to SYNC. This step ignores `baud_tick`.
- **SYNC:** wait for `baud_tick`. On tick: `tx <= 0`, go to START.
- **START, on tick:** `tx <= shreg[0]`, `bitcnt <= 0`, go to DATA.
- **DATA, on tick:**
  - If `bitcnt < 7`: `tx <= shreg[bitcnt+1]`, `bitcnt++`.
  - Else, if `PARITY != 0`: `tx <= parity bit`, go to PARITY.
  - Else: `tx <= 1`, `stopcnt <= 0`, go to STOP.
- **PARITY, on tick:** `tx <= 1`, `stopcnt <= 0`, go to STOP.
- **Parity bit:** even = `^shreg`; odd = `~^shreg`.
- **STOP, on tick:**
  - If `stopcnt < STOP_BITS-1`: `stopcnt++`, `tx` stays 1.
  - Else, if `hold_full`: load `shreg <= hold`, clear `hold_full`, `tx <= 0`, go to START. This gives back-to-back frames.
  - Else: `tx` stays 1, go to IDLE.
- **Tick filtering:** outside SYNC/START/DATA/PARITY/STOP, `baud_tick` has no effect. Within those states, the state only changes on a tick.
- **`tx_data` stability:** the source may change `tx_data` after acceptance; the frame uses the latched copy.
- **Reset (async, any time, including mid-frame):**
  - State IDLE, `tx = 1`, `hold_full = 0` (`tx_ready = 1`), `busy = 0`, counters 0.
  - Any partial frame and any held byte are discarded.
- **Frame length in bit periods:** 1 start + 8 data + (1 if parity) + `STOP_BITS`. For 8N1 this is 10.

## Timing
- Every bit on `tx` lasts exactly one tick period. `tx` changes on the `clk` edge where `baud_tick` is sampled high.
- **Accept to start bit:**
  - Byte accepted at edge E (IDLE, hold empty).
  - `hold_full` is set at E; the IDLE drain into `shreg` happens at E+1, entering SYNC.
  - `tx` falls at the first edge ≥ E+2 that samples `baud_tick`. Latency is 2 clocks plus up to one tick period.
- **`tx_ready`:** deasserts the cycle after acceptance and re-asserts the cycle after the drain.
  - From IDLE, the drain happens one cycle after acceptance.
  - During a frame, the drain happens at the last stop-bit tick.
- **Back-to-back frames:** a byte accepted any time before the final stop-bit tick starts its start bit on that same tick, with no extra idle bit.
- **`busy`:** registered from state. It rises one cycle after acceptance (on the IDLE-to-SYNC transition) and falls on the edge entering IDLE.

## Test plan
- **Reset state:** assert `rst` asynchronously mid-cycle -> `tx=1`, `tx_ready=1`, `busy=0` immediately, held through release.
- **8N1 frame:** `baud_tick` every 8 clocks; send 0xA3 -> `tx` sequence per tick 0,1,1,0,0,0,1,0,1,1, then idle high. `busy` high from 1 clock after accept until the final stop-bit tick.
- **Parity:** `PARITY=2`, 0xA3 -> parity bit 0. `PARITY=1`, 0xA3 -> parity bit 1, then 1 stop bit. `STOP_BITS=2`, 8N2 0x00 -> 11-tick frame ending in 1,1.
- **Back-to-back:** `tx_valid` held with 0x55 then 0xFF -> second byte accepted at the first cycle `tx_ready` re-asserts (IDLE drain + 1), its start bit on the tick ending the first stop bit, no gap. `tx_ready` low while `hold_full`.
- **Reset mid-frame:** assert `rst` during data bit 4 -> `tx=1`, state IDLE, held byte lost. Next byte 0x3C sends a clean full frame.
- **Tick aligned with accept:** `baud_tick` high on the same edge as acceptance in IDLE -> that tick is ignored. Start bit begins at the following tick, and the start bit is a full period.
